// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter/sequencer sharing a single-port word memory between the
// pipeline memory stage (port 0) and a loader/debug port (port 1).
module dm_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_op,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_op,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic [31:0]       m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic [1:0]        state_dbg
);
    // Handshake: a port raises req with stable fields and holds them until its
    // one-cycle ack; req sampled in IDLE always starts a new transaction.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic        last, last_nx;
    logic        sel;
    logic        grant, win;
    logic        l_we;
    logic [2:0]  l_op;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        is_word, is_half, is_byte, is_signed;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic        addr_hi_unused;

    assign addr_hi_unused = ^l_addr[31:ADDR_W+2];

    assign is_half   = (l_op == 3'd1) || (l_op == 3'd3);
    assign is_byte   = (l_op == 3'd2) || (l_op == 3'd4);
    assign is_word   = !is_half && !is_byte;
    assign is_signed = (l_op == 3'd1) || (l_op == 3'd2);

    always_comb begin
        state_nx = state;
        last_nx  = last;
        grant    = 1'b0;
        win      = 1'b0;
        case (state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    grant    = 1'b1;
                    state_nx = S_ISSUE;
                    if (m0_req && m1_req) begin
                        win     = ~last;
                        last_nx = ~last;
                    end else begin
                        win = m1_req;
                    end
                end
            end
            S_ISSUE: state_nx = (l_we && is_word) ? S_DONE : S_WAIT;
            S_WAIT:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes store data.
    always_comb begin
        merged = mem_rdata;
        if (is_byte) begin
            merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
        end else if (is_half) begin
            merged[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
        end
    end

    always_comb begin
        load_val = mem_rdata;
        if (is_byte) begin
            load_val[7:0]  = mem_rdata[{l_addr[1:0], 3'b000} +: 8];
            load_val[31:8] = {24{is_signed & load_val[7]}};
        end else if (is_half) begin
            load_val[15:0]  = mem_rdata[{l_addr[1], 4'b0000} +: 16];
            load_val[31:16] = {16{is_signed & load_val[15]}};
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = l_addr[ADDR_W+1:2];
                if (l_we && is_word) begin
                    mem_we    = 1'b1;
                    mem_wdata = l_wdata;
                end
            end
            S_WAIT: begin
                mem_addr = l_addr[ADDR_W+1:2];
                if (l_we) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = merged;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            last     <= 1'b1;
            sel      <= 1'b0;
            l_we     <= 1'b0;
            l_op     <= 3'd0;
            l_addr   <= '0;
            l_wdata  <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state  <= state_nx;
            last   <= last_nx;
            m0_ack <= (state_nx == S_DONE) && !sel;
            m1_ack <= (state_nx == S_DONE) && sel;
            if (grant) begin
                sel     <= win;
                l_we    <= win ? m1_we    : m0_we;
                l_op    <= win ? m1_op    : m0_op;
                l_addr  <= win ? m1_addr  : m0_addr;
                l_wdata <= win ? m1_wdata : m0_wdata;
            end
            if (state == S_WAIT && !l_we) begin
                if (sel) m1_rdata <= load_val;
                else     m0_rdata <= load_val;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural single-port memory.
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [2:0]  m0_op = 0, m1_op = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we, busy;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic [1:0]  state_dbg;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_bad = 0;
    int stray = 0;

    logic        cyc_en [0:10];
    logic        cyc_we [0:10];
    logic [11:0] cyc_addr [0:10];
    logic [31:0] cyc_wd [0:10];
    logic [1:0]  cyc_st [0:10];

    dm_port_arbiter #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_op(m0_op), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_op(m1_op), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / memory model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            m0_req = req; m0_we = we; m0_op = op; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_op = op; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Issues one transaction from IDLE; lat is the ack cycle counted from grant (cycle 0).
    task automatic do_txn(input int port, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
        bit got;
        got = 0; lat = 0; rdata = 0;
        drive(port, 1'b1, we, op, addr, wdata);
        for (int i = 1; i <= 10 && !got; i++) begin
            @(posedge clk); #1;
            cyc_en[i] = mem_en; cyc_we[i] = mem_we; cyc_addr[i] = mem_addr;
            cyc_wd[i] = mem_wdata; cyc_st[i] = state_dbg;
            if ((port == 0) ? m1_ack : m0_ack) stray++;
            if ((port == 0) ? m0_ack : m1_ack) begin
                got = 1; lat = i;
                rdata = (port == 0) ? m0_rdata : m1_rdata;
            end
        end
        drive(port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    logic [31:0] rd;
    int lat;

    initial begin
        // reset state
        do_reset();
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("rst_acks", {30'd0, m0_ack, m1_ack}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);

        // word store then load on port 0
        do_txn(0, 1, 3'd0, 32'h10, 32'hDEADBEEF, rd, lat);
        check("ws_c1_we", {31'd0, cyc_we[1]}, 32'd1);
        check("ws_c1_addr", {20'd0, cyc_addr[1]}, 32'd4);
        check("ws_c1_wdata", cyc_wd[1], 32'hDEADBEEF);
        check("ws_lat", lat, 32'd2);
        do_txn(0, 0, 3'd0, 32'h10, 32'h0, rd, lat);
        check("ld_c1_en_we", {30'd0, cyc_en[1], cyc_we[1]}, 32'b10);
        check("ld_data", rd, 32'hDEADBEEF);
        check("ld_lat", lat, 32'd3);

        // byte / half read-modify-write stores on port 1
        do_txn(0, 1, 3'd0, 32'h10, 32'h11223344, rd, lat);
        do_txn(1, 1, 3'd2, 32'h13, 32'h123456AA, rd, lat);
        check("bs_c1_en_we", {30'd0, cyc_en[1], cyc_we[1]}, 32'b10);
        check("bs_c2_en_we", {30'd0, cyc_en[2], cyc_we[2]}, 32'b11);
        check("bs_c2_wdata", cyc_wd[2], 32'hAA223344);
        check("bs_c2_addr", {20'd0, cyc_addr[2]}, 32'd4);
        check("bs_lat", lat, 32'd3);
        do_txn(1, 1, 3'd1, 32'h12, 32'h00005566, rd, lat);
        check("hs_c2_wdata", cyc_wd[2], 32'h55663344);
        do_txn(1, 1, 3'd4, 32'h10, 32'hFFFFFF77, rd, lat);
        check("bs_u_c2_wdata", cyc_wd[2], 32'h55663377);
        do_txn(1, 0, 3'd0, 32'h10, 32'h0, rd, lat);
        check("rmw_readback", rd, 32'h55663377);

        // load extension
        do_txn(1, 1, 3'd0, 32'h0, 32'h80FF7F01, rd, lat);
        do_txn(0, 0, 3'd2, 32'h1, 32'h0, rd, lat);
        check("ld_b_s_1", rd, 32'h0000007F);
        do_txn(0, 0, 3'd2, 32'h2, 32'h0, rd, lat);
        check("ld_b_s_2", rd, 32'hFFFFFFFF);
        do_txn(0, 0, 3'd4, 32'h3, 32'h0, rd, lat);
        check("ld_b_u_3", rd, 32'h00000080);
        do_txn(0, 0, 3'd1, 32'h2, 32'h0, rd, lat);
        check("ld_h_s_2", rd, 32'hFFFF80FF);
        do_txn(1, 0, 3'd3, 32'h0, 32'h0, rd, lat);
        check("ld_h_u_0", rd, 32'h00007F01);
        do_txn(1, 0, 3'd1, 32'h3, 32'h0, rd, lat);
        check("ld_h_misalign", rd, 32'hFFFF80FF);
        do_txn(0, 0, 3'd6, 32'h1, 32'h0, rd, lat);
        check("ld_op6_word", rd, 32'h80FF7F01);
        do_txn(0, 0, 3'd0, 32'h4000_0000, 32'h0, rd, lat);
        check("ld_hi_addr_a", {20'd0, cyc_addr[1]}, 32'd0);
        check("ld_hi_addr_d", rd, 32'h80FF7F01);
        check("no_stray_ack", stray, 32'd0);

        // both ports requesting continuously from reset
        begin
            int acks, dual, wide;
            logic prev0, prev1;
            logic [1:0] order [0:3];
            logic [31:0] data [0:3];
            acks = 0; dual = 0; wide = 0; prev0 = 0; prev1 = 0;
            do_reset();
            drive(0, 1'b1, 1'b0, 3'd0, 32'h10, 32'h0);
            drive(1, 1'b1, 1'b0, 3'd0, 32'h0, 32'h0);
            for (int i = 0; i < 40 && acks < 4; i++) begin
                @(posedge clk); #1;
                if (m0_ack && m1_ack) dual++;
                if ((m0_ack && prev0) || (m1_ack && prev1)) wide++;
                prev0 = m0_ack; prev1 = m1_ack;
                if (m0_ack || m1_ack) begin
                    order[acks] = m1_ack ? 2'd1 : 2'd0;
                    data[acks] = m1_ack ? m1_rdata : m0_rdata;
                    acks++;
                end
            end
            drive(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            @(posedge clk); #1;
            if (m0_ack && prev0) wide++;
            if (m1_ack && prev1) wide++;
            check("rr_ack_count", acks, 32'd4);
            check("rr_dual_ack", dual, 32'd0);
            check("rr_wide_ack", wide, 32'd0);
            if (acks == 4) begin
                check("rr_order0", {30'd0, order[0]}, 32'd0);
                check("rr_order1", {30'd0, order[1]}, 32'd1);
                check("rr_order2", {30'd0, order[2]}, 32'd0);
                check("rr_order3", {30'd0, order[3]}, 32'd1);
                check("rr_data0", data[0], 32'h55663377);
                check("rr_data1", data[1], 32'h80FF7F01);
            end
            @(posedge clk); #1;
        end

        // reset during WAIT of a byte store
        begin
            int late_ack;
            late_ack = 0;
            drive(1, 1'b1, 1'b1, 3'd2, 32'h13, 32'hBB);
            @(posedge clk); #1;
            @(posedge clk); #1;
            check("abort_in_wait", {30'd0, state_dbg}, 32'd2);
            reset = 1'b1;
            drive(1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
            @(posedge clk); #1;
            check("abort_state", {30'd0, state_dbg}, 32'd0);
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_mem_en", {31'd0, mem_en}, 32'd0);
            check("abort_ack", {30'd0, m0_ack, m1_ack}, 32'd0);
            reset = 1'b0;
            repeat (3) begin
                @(posedge clk); #1;
                if (m1_ack || m0_ack) late_ack++;
            end
            check("abort_late_ack", late_ack, 32'd0);
            do_txn(1, 0, 3'd0, 32'h0, 32'h0, rd, lat);
            check("post_abort_c1", {30'd0, cyc_st[1]}, 32'd1);
            check("post_abort_lat", lat, 32'd3);
            check("post_abort_data", rd, 32'h80FF7F01);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
